mod_count_checker: RTL and testbench
====================================

Name: mod_count_checker

Overview:
- Receive-side companion to the mod-N counter: samples a count bus produced by a modulo counter and checks that the sequence advances by exactly +1 modulo MOD.
- Reports lock status, sequence and range errors, and wrap events, and keeps a saturating error tally.
- Sits on the consumer end of any counter link, e.g. the mod-12 counter output, and is used both in-system and as a bench monitor.

Parameters:
- MOD, 12, modulus of the observed counter; legal values are 0..MOD-1.
- WIDTH, 4, width of count_in and expected; must satisfy 2^WIDTH >= MOD.
- LOCK_CNT, 3, number of consecutive correct increments required to declare lock.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock; rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  count_in is sampled on a rising edge only when high.
- count_in  input  WIDTH  observed counter value.
- clear_err  input  1  synchronous clear of err_count.
- locked  output  1  high while in LOCKED state.
- expected  output  WIDTH  next value predicted: (last accepted sample + 1) mod MOD.
- seq_err  output  1  one-cycle pulse on a sequence break while locked.
- range_err  output  1  one-cycle pulse when a sampled value is >= MOD.
- wrap  output  1  one-cycle pulse on an observed MOD-1 -> 0 transition while locked.
- err_count  output  ERR_CNT_W  saturating count of seq_err events.

Behaviour:
- All outputs are registered. A sample taken at edge N is reflected in the outputs after edge N (latency 1 cycle).
- Pulses last exactly one cycle.
- Reset (async, active-high): state=HUNT, prev=0, match_cnt=0. Outputs: locked=0, expected=0, seq_err=0, range_err=0, wrap=0, err_count=0. Asserting reset mid-operation clears everything immediately, regardless of clk.
- in_valid=0: no state change, no pulses; count_in is ignored.
- FSM states HUNT, ACQUIRE, LOCKED; transitions evaluated only on valid samples:
  - HUNT:
    - In-range sample: prev=sample, match_cnt=0, go to ACQUIRE.
    - Out-of-range sample: range_err pulse, stay in HUNT.
  - ACQUIRE:
    - sample == (prev+1) mod MOD: match_cnt+1, prev=sample. When match_cnt reaches LOCK_CNT, go to LOCKED and set locked=1.
    - In-range mismatch: prev=sample, match_cnt=0, stay in ACQUIRE. No seq_err.
    - Out-of-range: range_err pulse, go to HUNT.
  - LOCKED:
    - sample == expected: prev=sample. If the old prev == MOD-1 and sample == 0, pulse wrap.
    - In-range mismatch: seq_err pulse, err_count+1, prev=sample, match_cnt=0, go to ACQUIRE, locked=0.
    - Out-of-range: seq_err and range_err pulse together, err_count+1, go to HUNT, locked=0.
- expected is always updated from prev as (prev+1) mod MOD. Compute it with an explicit compare to MOD-1, never relying on natural binary overflow.
- A repeated value, e.g. 5,5, counts as a mismatch. A backwards step counts as a mismatch.
- err_count saturates at 2^ERR_CNT_W-1 and does not wrap.
- clear_err sets err_count=0 on the next edge. If it coincides with an error increment, clear wins and err_count=0. seq_err still pulses in that case.
- The locked-to-LOCKED qualification needs LOCK_CNT+1 samples from HUNT (for default MOD=12, LOCK_CNT=3: 4 consecutive valid in-sequence samples).

Test Plan:
- Reset, then valid every cycle with 0,1,2,...,11,0,1 → locked=1 after the edge sampling 3. expected=4 at the same time. wrap pulses once, after the edge sampling the 0 that follows 11. seq_err never asserted, err_count=0.
- While locked after 5, drive 7 → seq_err pulses one cycle, err_count=1, locked=0. Then 8,9,10 → locked=1 after the edge sampling 10.
- While locked after 4, drive 13 → seq_err and range_err pulse together, err_count+1, state HUNT. Then 0,1,2,3 → relock after 3.
- Toggle in_valid 1/0 each cycle with the correct sequence on valid cycles and garbage (e.g. 15) on invalid cycles → no pulses, locked held, expected unchanged across invalid cycles.
- Force 300 sequence breaks (relock between each) → err_count stops at 255. Assert clear_err in the same cycle as an error → seq_err pulses, err_count=0.
- Assert reset asynchronously between clock edges while locked with err_count=3 → locked=0, err_count=0, expected=0 immediately. After release, 4 in-sequence samples are needed to relock.

Source files
------------

// File: rtl/mod_count_checker.sv
// rtl/mod_count_checker.sv - sequence checker for a modulo-MOD counter bus
// Locks onto a +1 mod MOD stream and flags breaks, out-of-range values and wraps.
module mod_count_checker #(
  parameter int MOD       = 12,
  parameter int WIDTH     = 4,
  parameter int LOCK_CNT  = 3,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     count_in,
  input  logic                 clear_err,
  output logic                 locked,
  output logic [WIDTH-1:0]     expected,
  output logic                 seq_err,
  output logic                 range_err,
  output logic                 wrap,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {HUNT, ACQUIRE, LOCKED} state_e;

  localparam int                   MW          = $clog2(LOCK_CNT + 1);
  localparam logic [WIDTH-1:0]     MOD_M1      = WIDTH'(MOD - 1);
  localparam logic [MW-1:0]        MATCH_ONE   = MW'(1);
  localparam logic [MW-1:0]        LOCK_TARGET = MW'(LOCK_CNT);
  localparam logic [ERR_CNT_W-1:0] ERR_ONE     = ERR_CNT_W'(1);

  // Successor uses an explicit compare so MOD need not be a power of two.
  function automatic logic [WIDTH-1:0] succ(input logic [WIDTH-1:0] v);
    return (v == MOD_M1) ? '0 : v + WIDTH'(1);
  endfunction

  state_e                 state_q;
  logic [WIDTH-1:0]       prev_q;
  logic [WIDTH-1:0]       expected_q;
  logic [MW-1:0]          match_q;
  logic                   locked_q;
  logic                   seq_err_q;
  logic                   range_err_q;
  logic                   wrap_q;
  logic [ERR_CNT_W-1:0]   err_count_q;

  logic                   in_range;
  logic                   seq_ok;
  logic                   seq_hit;
  logic [MW-1:0]          match_d;
  logic [ERR_CNT_W-1:0]   err_count_d;

  assign in_range = (count_in <= MOD_M1);
  assign seq_ok   = (count_in == succ(prev_q));
  assign seq_hit  = in_valid && (state_q == LOCKED) && !seq_ok;
  assign match_d  = match_q + MATCH_ONE;

  // Clear takes priority over a coincident increment; saturate at all-ones.
  assign err_count_d = clear_err ? '0 :
                       (seq_hit && (err_count_q != '1)) ? err_count_q + ERR_ONE :
                       err_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= HUNT;
      prev_q      <= '0;
      expected_q  <= '0;
      match_q     <= '0;
      locked_q    <= 1'b0;
      seq_err_q   <= 1'b0;
      range_err_q <= 1'b0;
      wrap_q      <= 1'b0;
      err_count_q <= '0;
    end else begin
      seq_err_q   <= 1'b0;
      range_err_q <= 1'b0;
      wrap_q      <= 1'b0;
      err_count_q <= err_count_d;
      if (in_valid) begin
        case (state_q)
          HUNT: begin
            if (!in_range) begin
              range_err_q <= 1'b1;
            end else begin
              prev_q     <= count_in;
              expected_q <= succ(count_in);
              match_q    <= '0;
              state_q    <= ACQUIRE;
            end
          end
          ACQUIRE: begin
            if (!in_range) begin
              range_err_q <= 1'b1;
              match_q     <= '0;
              state_q     <= HUNT;
            end else if (seq_ok) begin
              prev_q     <= count_in;
              expected_q <= succ(count_in);
              match_q    <= match_d;
              if (match_d == LOCK_TARGET) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
              end
            end else begin
              prev_q     <= count_in;
              expected_q <= succ(count_in);
              match_q    <= '0;
            end
          end
          LOCKED: begin
            if (!in_range) begin
              seq_err_q   <= 1'b1;
              range_err_q <= 1'b1;
              match_q     <= '0;
              locked_q    <= 1'b0;
              state_q     <= HUNT;
            end else if (seq_ok) begin
              prev_q     <= count_in;
              expected_q <= succ(count_in);
              wrap_q     <= (prev_q == MOD_M1) && (count_in == '0);
            end else begin
              seq_err_q  <= 1'b1;
              prev_q     <= count_in;
              expected_q <= succ(count_in);
              match_q    <= '0;
              locked_q   <= 1'b0;
              state_q    <= ACQUIRE;
            end
          end
          default: begin
            state_q  <= HUNT;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign locked    = locked_q;
  assign expected  = expected_q;
  assign seq_err   = seq_err_q;
  assign range_err = range_err_q;
  assign wrap      = wrap_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_mod_count_checker.sv
// tb/tb_mod_count_checker.sv - scoreboard bench for mod_count_checker
module tb_mod_count_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [3:0] count_in;
  logic       clear_err;
  logic       locked;
  logic [3:0] expected;
  logic       seq_err;
  logic       range_err;
  logic       wrap;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;
  int step_no = 0;

  typedef struct {
    int id;
    int lk;
    int ex;
    int se;
    int re;
    int wr;
    int ec;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  mod_count_checker #(.MOD(12), .WIDTH(4), .LOCK_CNT(3), .ERR_CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .count_in  (count_in),
    .clear_err (clear_err),
    .locked    (locked),
    .expected  (expected),
    .seq_err   (seq_err),
    .range_err (range_err),
    .wrap      (wrap),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int id, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s step %0d: got %0d, required %0d", name, id, act, req);
    end
  endtask

  // ex < 0 marks the expected output as unspecified for that vector.
  task automatic step(input int v, input int c, input int clr, input int lk, input int ex,
                      input int se, input int re, input int wr, input int ec);
    exp_t e;
    @(negedge clk);
    in_valid  = v[0];
    count_in  = 4'(c);
    clear_err = clr[0];
    step_no++;
    e.id = step_no; e.lk = lk; e.ex = ex; e.se = se; e.re = re; e.wr = wr; e.ec = ec;
    sb.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("locked", mon_e.id, int'(locked), mon_e.lk);
      if (mon_e.ex >= 0) chk("expected", mon_e.id, int'(expected), mon_e.ex);
      chk("seq_err", mon_e.id, int'(seq_err), mon_e.se);
      chk("range_err", mon_e.id, int'(range_err), mon_e.re);
      chk("wrap", mon_e.id, int'(wrap), mon_e.wr);
      chk("err_count", mon_e.id, int'(err_count), mon_e.ec);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, b, v, ec;
    reset = 1'b1; in_valid = 1'b0; count_in = '0; clear_err = 1'b0;
    #1;
    chk("rst_locked", 0, int'(locked), 0);
    chk("rst_expected", 0, int'(expected), 0);
    chk("rst_pulses", 0, int'({seq_err, range_err, wrap}), 0);
    chk("rst_err_count", 0, int'(err_count), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Clean run 0..11,0,1: lock after sampling 3, wrap after the 0 following 11.
    for (int i = 0; i < 14; i++)
      step(1, i % 12, 0, int'(i >= 3), (i % 12 + 1) % 12, 0, 0, int'(i == 12), 0);

    // Locked, prev=1: 2..5 then skip to 7.
    for (int i = 2; i <= 5; i++) step(1, i, 0, 1, i + 1, 0, 0, 0, 0);
    step(1, 7, 0, 0, 8, 1, 0, 0, 1);
    step(1, 8, 0, 0, 9, 0, 0, 0, 1);
    step(1, 9, 0, 0, 10, 0, 0, 0, 1);
    step(1, 10, 0, 1, 11, 0, 0, 0, 1);

    // Out-of-range while locked after 4.
    step(1, 11, 0, 1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 1, 1, 0, 0, 1, 1);
    for (int i = 1; i <= 4; i++) step(1, i, 0, 1, i + 1, 0, 0, 0, 1);
    step(1, 13, 0, 0, -1, 1, 1, 0, 2);
    step(1, 0, 0, 0, 1, 0, 0, 0, 2);
    step(1, 1, 0, 0, 2, 0, 0, 0, 2);
    step(1, 2, 0, 0, 3, 0, 0, 0, 2);
    step(1, 3, 0, 1, 4, 0, 0, 0, 2);

    // Alternating valid / garbage-invalid cycles.
    for (int k = 0; k < 10; k++) begin
      v = (4 + k) % 12;
      step(1, v, 0, 1, (v + 1) % 12, 0, 0, int'(v == 0), 2);
      step(0, 15, 0, 1, (v + 1) % 12, 0, 0, 0, 2);
    end

    // Clear on a clean cycle, then 300 breaks with relock in between.
    step(1, 2, 1, 1, 3, 0, 0, 0, 0);
    p = 2;
    for (int k = 1; k <= 300; k++) begin
      ec = (k < 255) ? k : 255;
      b = (p + 2) % 12;
      step(1, b, 0, 0, (b + 1) % 12, 1, 0, 0, ec);
      for (int j = 1; j <= 3; j++) begin
        v = (b + j) % 12;
        step(1, v, 0, int'(j == 3), (v + 1) % 12, 0, 0, 0, ec);
      end
      p = (b + 3) % 12;
    end
    b = (p + 2) % 12;
    step(1, b, 1, 0, (b + 1) % 12, 1, 0, 0, 0);
    for (int j = 1; j <= 3; j++) begin
      v = (b + j) % 12;
      step(1, v, 0, int'(j == 3), (v + 1) % 12, 0, 0, 0, 0);
    end
    p = (b + 3) % 12;

    // Build err_count=3 while locked, then async reset between edges.
    for (int k = 1; k <= 3; k++) begin
      b = (p + 2) % 12;
      step(1, b, 0, 0, (b + 1) % 12, 1, 0, 0, k);
      for (int j = 1; j <= 3; j++) begin
        v = (b + j) % 12;
        step(1, v, 0, int'(j == 3), (v + 1) % 12, 0, 0, 0, k);
      end
      p = (b + 3) % 12;
    end
    @(posedge clk);
    #3;
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("async_locked", step_no, int'(locked), 0);
    chk("async_err_count", step_no, int'(err_count), 0);
    chk("async_expected", step_no, int'(expected), 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) step(1, i, 0, int'(i == 3), i + 1, 0, 0, 0, 0);
    @(negedge clk);
    in_valid = 1'b0;

    for (int t = 0; t < 20 && sb.size() > 0; t++) @(posedge clk);
    #3;
    chk("scoreboard_drained", step_no, sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
